// File: rtl/i2c_frame_tx.sv
// Bit-level I2C master transmitter: sends an NBYTES command frame with START,
// per-byte ACK slots and STOP, flags NACK, and pulses o_finished at frame end.
module i2c_frame_tx #(
  parameter int unsigned CLK_DIV = 30,
  parameter int unsigned NBYTES  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [8*NBYTES-1:0]   i_data,
  input  logic                  i_sdat,
  output logic                  o_busy,
  output logic                  o_finished,
  output logic                  o_ack_err,
  output logic                  o_sclk,
  output logic                  o_sdat,
  output logic                  o_oen
);

  localparam int unsigned FW = 8 * NBYTES;
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [FW-1:0]   shift_q, shift_d;
  logic            err_q, err_d;
  logic            sclk_q, sclk_d, sdat_q, sdat_d, oen_q, oen_d;
  logic            busy_q, busy_d, fin_q, fin_d;
  logic            qend, qlast;

  assign qend  = (cnt_q == CW'(CLK_DIV - 1));
  assign qlast = qend && (qtr_q == 2'd3);

  // Next state: quarter timer, bit/byte sequencing and ACK sampling
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_START;
          shift_d = i_data;
          bit_d   = '0;
          byte_d  = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          qtr_d   = '0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        cnt_d = qend ? '0 : cnt_q + CW'(1);
        if (qend) qtr_d = qtr_q + 2'd1;
        if (state_q == S_ACK && qend && qtr_q == 2'd1 && i_sdat) err_d = 1'b1;
        if (qlast) begin
          case (state_q)
            S_START: state_d = S_BIT;
            S_BIT: begin
              shift_d = {shift_q[FW-2:0], 1'b0};
              if (bit_q == 3'd7) begin
                bit_d   = '0;
                state_d = S_ACK;
              end else begin
                bit_d = bit_q + 3'd1;
              end
            end
            // err_q already holds this slot's sample taken at the end of q1
            S_ACK: begin
              if (err_q || byte_q == BW'(NBYTES - 1)) begin
                state_d = S_STOP;
              end else begin
                byte_d  = byte_q + BW'(1);
                state_d = S_BIT;
              end
            end
            S_STOP:  state_d = S_DONE;
            default: state_d = state_q;
          endcase
        end
      end
    endcase
  end

  // Output values for the upcoming cycle, registered below
  always_comb begin
    sclk_d = 1'b1;
    sdat_d = 1'b1;
    oen_d  = 1'b1;
    case (state_d)
      S_START: begin
        sclk_d = (qtr_d != 2'd3);
        sdat_d = (qtr_d == 2'd0);
      end
      S_BIT: begin
        sclk_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sdat_d = shift_d[FW-1];
      end
      S_ACK: begin
        sclk_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        oen_d  = 1'b0;
      end
      S_STOP: begin
        sclk_d = (qtr_d != 2'd0);
        sdat_d = qtr_d[1];
      end
      default: ;
    endcase
    busy_d = (state_d == S_START) || (state_d == S_BIT) ||
             (state_d == S_ACK) || (state_d == S_STOP);
    fin_d  = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      err_q   <= 1'b0;
      sclk_q  <= 1'b1;
      sdat_q  <= 1'b1;
      oen_q   <= 1'b1;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      err_q   <= err_d;
      sclk_q  <= sclk_d;
      sdat_q  <= sdat_d;
      oen_q   <= oen_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  assign o_sclk     = sclk_q;
  assign o_sdat     = sdat_q;
  assign o_oen      = oen_q;
  assign o_busy     = busy_q;
  assign o_finished = fin_q;
  assign o_ack_err  = err_q;

endmodule

// File: tb/tb_i2c_frame_tx.sv
// Bench for i2c_frame_tx: per-quarter waveform model built from the frame
// bytes and ACK plan, for CLK_DIV=2 and CLK_DIV=1 instances.
module tb_i2c_frame_tx;

  localparam int unsigned D0 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        sel;
  logic [23:0] i_data;
  logic        i_sdat;

  logic st0, st1;
  logic busy0, fin0, err0, scl0, sda0, oen0;
  logic busy1, fin1, err1, scl1, sda1, oen1;
  logic m_busy, m_fin, m_err, m_scl, m_sda, m_oen;

  assign st0 = i_start & ~sel;
  assign st1 = i_start & sel;

  i2c_frame_tx #(.CLK_DIV(D0), .NBYTES(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(st0), .i_data(i_data), .i_sdat(i_sdat),
    .o_busy(busy0), .o_finished(fin0), .o_ack_err(err0),
    .o_sclk(scl0), .o_sdat(sda0), .o_oen(oen0)
  );

  i2c_frame_tx #(.CLK_DIV(1), .NBYTES(3)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(st1), .i_data(i_data), .i_sdat(i_sdat),
    .o_busy(busy1), .o_finished(fin1), .o_ack_err(err1),
    .o_sclk(scl1), .o_sdat(sda1), .o_oen(oen1)
  );

  assign m_busy = sel ? busy1 : busy0;
  assign m_fin  = sel ? fin1  : fin0;
  assign m_err  = sel ? err1  : err0;
  assign m_scl  = sel ? scl1  : scl0;
  assign m_sda  = sel ? sda1  : sda0;
  assign m_oen  = sel ? oen1  : oen0;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Slave model: answers each ACK window with the planned bit, else idles high
  logic [2:0] ack_plan = 3'b000;
  int         ack_idx  = 0;
  logic       prev_oen = 1'b1;
  always @(negedge clk) begin
    if (!m_busy) ack_idx = 0;
    else if (!prev_oen && m_oen) ack_idx++;
    prev_oen = m_oen;
    i_sdat = (!m_oen && ack_idx < 3) ? ack_plan[ack_idx] : 1'b1;
  end

  // Reference: one {scl,sda,oen} entry per quarter, plus expected SCL-rise bits
  logic [2:0] eq[$];
  logic       eb[$];
  logic       exp_err;
  int         exp_acks;

  task automatic build(input logic [23:0] d, input logic [2:0] nack);
    logic [7:0] by;
    eq.delete();
    eb.delete();
    exp_err  = 1'b0;
    exp_acks = 0;
    eq.push_back(3'b111); eq.push_back(3'b101); eq.push_back(3'b101); eq.push_back(3'b001);
    for (int b = 0; b < 3; b++) begin
      by = d[23-8*b -: 8];
      for (int i = 7; i >= 0; i--) begin
        eq.push_back({1'b0, by[i], 1'b1});
        eq.push_back({1'b1, by[i], 1'b1});
        eq.push_back({1'b1, by[i], 1'b1});
        eq.push_back({1'b0, by[i], 1'b1});
        eb.push_back(by[i]);
      end
      eq.push_back(3'b010); eq.push_back(3'b110); eq.push_back(3'b110); eq.push_back(3'b010);
      exp_acks++;
      if (nack[b]) begin
        exp_err = 1'b1;
        break;
      end
    end
    eq.push_back(3'b001); eq.push_back(3'b101); eq.push_back(3'b111); eq.push_back(3'b111);
    eb.push_back(1'b0);
  endtask

  task automatic accept(input logic [23:0] d);
    @(negedge clk);
    i_data  = d;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic run_frame(input logic [23:0] d, input logic [2:0] nack, input bit pre,
                           input bit scramble, input int p0, input int p1, input int p2);
    int         dv;
    int         nq;
    int         owin;
    bit         ok;
    logic       pscl;
    logic       poen;
    logic [2:0] e;
    logic       cap[$];
    dv = sel ? 1 : int'(D0);
    build(d, nack);
    ack_plan = nack;
    nq = eq.size();
    if (pre) begin
      @(posedge clk);
      #1 i_start = 1'b0;
    end else begin
      accept(d);
    end
    if (scramble) i_data = 24'($urandom);
    pscl = 1'b1;
    poen = 1'b1;
    owin = 0;
    for (int n = 1; n <= nq * dv + 1; n++) begin
      @(negedge clk);
      i_start = (n == p0) || (n == p1) || (n == p2);
      if (n == 1) begin
        n_checks++;
        if (m_err !== 1'b0) $display("FAIL ack_err_clear got=%b exp=0", m_err);
        else n_pass++;
      end
      if (n <= nq * dv) begin
        e = eq[(n - 1) / dv];
        n_checks++;
        if (m_scl !== e[2] || m_oen !== e[0] || (e[0] && m_sda !== e[1]) ||
            m_busy !== 1'b1 || m_fin !== 1'b0)
          $display("FAIL wave cyc=%0d got scl=%b sda=%b oen=%b busy=%b fin=%b exp scl=%b sda=%b oen=%b busy=1 fin=0",
                   n, m_scl, m_sda, m_oen, m_busy, m_fin, e[2], e[1], e[0]);
        else n_pass++;
        if (m_scl && !pscl && m_oen) cap.push_back(m_sda);
        if (poen && !m_oen) owin++;
        pscl = m_scl;
        poen = m_oen;
      end else begin
        n_checks++;
        if (m_fin !== 1'b1 || m_busy !== 1'b0 || m_err !== exp_err)
          $display("FAIL finish cyc=%0d got fin=%b busy=%b err=%b exp fin=1 busy=0 err=%b",
                   n, m_fin, m_busy, m_err, exp_err);
        else n_pass++;
      end
    end
    ok = (cap.size() == eb.size());
    if (ok) foreach (eb[i]) if (cap[i] !== eb[i]) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL bits got_count=%0d exp_count=%0d data=%h", cap.size(), eb.size(), d);
    else n_pass++;
    n_checks++;
    if (owin != exp_acks) $display("FAIL ack_windows got=%0d exp=%0d", owin, exp_acks);
    else n_pass++;
  endtask

  task automatic check_idle(input string nm);
    n_checks++;
    if (m_scl !== 1'b1 || m_sda !== 1'b1 || m_oen !== 1'b1 || m_busy !== 1'b0 || m_fin !== 1'b0)
      $display("FAIL %s got scl=%b sda=%b oen=%b busy=%b fin=%b exp 1 1 1 0 0",
               nm, m_scl, m_sda, m_oen, m_busy, m_fin);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 check_idle("reset_async");
    n_checks++;
    if (m_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", m_err);
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_released");
  endtask

  task automatic test_basic();
    run_frame(24'h341E00, 3'b000, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_nack();
    run_frame(24'h341E00, 3'b001, 1'b0, 1'b0, 0, 0, 0);
    run_frame(24'h341E00, 3'b000, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_frame(24'h341E00, 3'b000, 1'b0, 1'b0, 5, 50, 232);
    i_data  = 24'hA5_5A_C3;
    i_start = 1'b1;
    @(negedge clk);
    check_idle("start_in_done_ignored");
    run_frame(24'hA55AC3, 3'b000, 1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic test_scramble();
    run_frame(24'($urandom), 3'b000, 1'b0, 1'b1, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int bad;
    accept(24'h341E00);
    repeat (99) @(negedge clk);
    rst = 1'b1;
    #1 check_idle("reset_mid_async");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (m_fin !== 1'b0 || m_busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL reset_mid_quiet got=%0d active cycles exp=0", bad);
    else n_pass++;
    run_frame(24'h341E00, 3'b000, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [2:0] nk;
    int         r;
    for (int k = 0; k < 5; k++) begin
      r  = int'($urandom_range(0, 3));
      nk = (r == 3) ? 3'b000 : 3'(1 << r);
      run_frame(24'($urandom), nk, 1'b0, 1'b0, 0, 0, 0);
    end
  endtask

  task automatic test_clkdiv1();
    sel = 1'b1;
    @(negedge clk);
    check_idle("div1_idle");
    run_frame(24'h341E00, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    run_frame(24'($urandom), 3'b010, 1'b0, 1'b0, 0, 0, 0);
    sel = 1'b0;
  endtask

  initial begin
    i_start = 1'b0;
    sel     = 1'b0;
    i_data  = '0;
    test_reset();
    test_basic();
    test_nack();
    test_back_to_back();
    test_scramble();
    test_reset_mid();
    test_random();
    test_clkdiv1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
